// File: rtl/dp_block_ram_pkg.sv
// Shared types for the dual-port block RAM.
// Contents: the clear-sweep state encoding used by dp_block_ram.
package dp_block_ram_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } clr_state_e;

endpackage

// File: rtl/dp_block_ram_bram.sv
// bram_array: storage for dp_block_ram. It has one write port with byte
// enables and one registered read port, written so that FPGA tools can map
// it to block RAM.
// Ports:
//   clk                      rising-edge clock
//   rst                      synchronous reset of the read register only
//   wr_en/wr_addr/wr_data    write port
//   wr_bytesel               per-byte write enable
//   rd_en/rd_addr            read request; the data is registered
//   rd_data                  registered read data (old contents on a collision)
module bram_array #(
  parameter int data_bits  = 32,
  parameter int nr_entries = 256,
  localparam int addr_bits = $clog2(nr_entries),
  localparam int nr_bytes  = data_bits / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [addr_bits-1:0] wr_addr,
  input  logic [data_bits-1:0] wr_data,
  input  logic [nr_bytes-1:0]  wr_bytesel,
  input  logic                 rd_en,
  input  logic [addr_bits-1:0] rd_addr,
  output logic [data_bits-1:0] rd_data
);

  logic [data_bits-1:0] mem [nr_entries];
  logic [data_bits-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < nr_bytes; b++) begin
        if (wr_bytesel[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read-before-write on a same-address collision. The sync reset maps onto
  // the output-register reset of the block RAM.
  always_ff @(posedge clk) begin
    if (rst)        rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dp_block_ram.sv
// dp_block_ram: byte-writable simple dual-port RAM with a whole-array clear
// sweep, an optional same-address write-first bypass and an optional output
// register.
// Ports:
//   clk, rst                 clock; synchronous active-high reset (reset also
//                            starts a clear sweep)
//   clear, busy              clear request; busy while the sweep runs
//   read_en/read_addr        read request; ignored while busy
//   read_data/read_valid     result, after 1 cycle (out_reg=0) or 2 (out_reg=1)
//   wr_en/write_addr/...     byte-enabled write; ignored while busy
//
// Clear FSM states:
//   state       | meaning
//   ST_IDLE     | normal operation, busy=0
//   ST_CLEARING | writing zero to mem[clr_addr] each cycle, busy=1
module dp_block_ram
  import dp_block_ram_pkg::*;
#(
  parameter int data_bits   = 32,
  parameter int nr_entries  = 256,
  parameter int write_first = 1,
  parameter int out_reg     = 0,
  localparam int addr_bits  = $clog2(nr_entries),
  localparam int nr_bytes   = data_bits / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  output logic                 busy,
  input  logic                 read_en,
  input  logic [addr_bits-1:0] read_addr,
  output logic [data_bits-1:0] read_data,
  output logic                 read_valid,
  input  logic                 wr_en,
  input  logic [addr_bits-1:0] write_addr,
  input  logic [data_bits-1:0] write_data,
  input  logic [nr_bytes-1:0]  write_bytesel
);

  localparam logic [addr_bits-1:0] last_addr = addr_bits'(nr_entries - 1);

  clr_state_e           state_q;
  logic [addr_bits-1:0] clr_addr_q;
  logic                 busy_q;

  logic                 user_wr;
  logic                 rd_accept;
  logic                 sweep_we;
  logic                 mem_we;
  logic [addr_bits-1:0] mem_addr;
  logic [data_bits-1:0] mem_wdata;
  logic [nr_bytes-1:0]  mem_be;
  logic [data_bits-1:0] ram_rdata;

  logic                 rd_vld1_q;
  logic                 byp_hit_q;
  logic [data_bits-1:0] byp_data_q;
  logic [nr_bytes-1:0]  byp_be_q;
  logic [data_bits-1:0] merged_d;

  assign user_wr   = wr_en & ~busy_q & ~rst;
  assign rd_accept = read_en & ~busy_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEARING;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear) begin
            state_q    <= ST_CLEARING;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        ST_CLEARING: begin
          if (clear) begin
            clr_addr_q <= '0;
          end else if (clr_addr_q == last_addr) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + addr_bits'(1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          clr_addr_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

  // The sweep owns the write port while CLEARING. User writes are already
  // blocked by busy, so the two sources never collide.
  always_comb begin
    sweep_we  = (state_q == ST_CLEARING) & ~rst;
    mem_we    = sweep_we | user_wr;
    mem_addr  = sweep_we ? clr_addr_q : write_addr;
    mem_wdata = sweep_we ? '0 : write_data;
    mem_be    = sweep_we ? '1 : write_bytesel;
  end

  bram_array #(
    .data_bits (data_bits),
    .nr_entries(nr_entries)
  ) u_bram (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (mem_we),
    .wr_addr   (mem_addr),
    .wr_data   (mem_wdata),
    .wr_bytesel(mem_be),
    .rd_en     (rd_accept),
    .rd_addr   (read_addr),
    .rd_data   (ram_rdata)
  );

  // The RAM returns old data on a collision. For write-first, remember the
  // colliding write so its bytes can be patched over the RAM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld1_q  <= 1'b0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
      byp_be_q   <= '0;
    end else begin
      rd_vld1_q <= rd_accept;
      if (rd_accept) begin
        byp_hit_q  <= (write_first != 0) && user_wr && (write_addr == read_addr);
        byp_data_q <= write_data;
        byp_be_q   <= write_bytesel;
      end
    end
  end

  always_comb begin
    merged_d = ram_rdata;
    for (int b = 0; b < nr_bytes; b++) begin
      if (byp_hit_q && byp_be_q[b]) merged_d[8*b +: 8] = byp_data_q[8*b +: 8];
    end
  end

  // Without the extra stage, read_data still holds between reads because the
  // RAM read register and the bypass registers only load on an accepted read.
  if (out_reg != 0) begin : g_out_reg
    logic [data_bits-1:0] read_data_q;
    logic                 read_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        read_data_q  <= '0;
        read_valid_q <= 1'b0;
      end else begin
        read_valid_q <= rd_vld1_q;
        if (rd_vld1_q) read_data_q <= merged_d;
      end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
  end else begin : g_no_out_reg
    assign read_data  = merged_d;
    assign read_valid = rd_vld1_q;
  end

endmodule

// File: tb/tb_dp_block_ram.sv
// Directed bench for dp_block_ram. Two instances share the same stimulus:
// dut_a is write-first with no output register, and dut_b is read-first with
// the output register.
module tb_dp_block_ram;

  localparam int DW = 32;
  localparam int NE = 16;
  localparam int AW = 4;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          read_en;
  logic          wr_en;
  logic [AW-1:0] read_addr;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [NB-1:0] write_bytesel;
  logic          busy_a, busy_b, valid_a, valid_b;
  logic [DW-1:0] data_a, data_b;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  dp_block_ram #(.data_bits(DW), .nr_entries(NE), .write_first(1), .out_reg(0)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy_a),
    .read_en(read_en), .read_addr(read_addr), .read_data(data_a), .read_valid(valid_a),
    .wr_en(wr_en), .write_addr(write_addr), .write_data(write_data),
    .write_bytesel(write_bytesel)
  );

  dp_block_ram #(.data_bits(DW), .nr_entries(NE), .write_first(0), .out_reg(1)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy_b),
    .read_en(read_en), .read_addr(read_addr), .read_data(data_b), .read_valid(valid_b),
    .wr_en(wr_en), .write_addr(write_addr), .write_data(write_data),
    .write_bytesel(write_bytesel)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [NB-1:0] be);
    wr_en = 1'b1; write_addr = addr; write_data = data; write_bytesel = be;
    tick();
    wr_en = 1'b0;
  endtask

  // Any write set up by the caller goes out on the same edge as the read.
  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_a,
                         input logic [DW-1:0] exp_b, input string tag);
    read_en = 1'b1; read_addr = addr;
    tick();
    read_en = 1'b0; wr_en = 1'b0;
    check_eq({tag, " a_valid"}, 32'(valid_a), 32'd1);
    check_eq({tag, " a_data"}, data_a, exp_a);
    check_eq({tag, " b_valid_early"}, 32'(valid_b), 32'd0);
    tick();
    check_eq({tag, " a_valid_one_cycle"}, 32'(valid_a), 32'd0);
    check_eq({tag, " b_valid"}, 32'(valid_b), 32'd1);
    check_eq({tag, " b_data"}, data_b, exp_b);
  endtask

  task automatic reset_and_wait(input string tag);
    int cnt_a = 0;
    int cnt_b = 0;
    rst = 1'b1; read_en = 1'b1; read_addr = '0;
    wr_en = 1'b1; write_addr = '0; write_data = '1; write_bytesel = '1;
    tick();
    rst = 1'b0; read_en = 1'b0; wr_en = 1'b0;
    check_eq({tag, " a_valid_rst"}, 32'(valid_a), 32'd0);
    check_eq({tag, " a_data_rst"}, data_a, 32'd0);
    check_eq({tag, " b_valid_rst"}, 32'(valid_b), 32'd0);
    check_eq({tag, " b_data_rst"}, data_b, 32'd0);
    for (int i = 0; i < 100 && (busy_a || busy_b); i++) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      tick();
    end
    check_eq({tag, " busy_done"}, 32'(busy_a | busy_b), 32'd0);
    check_eq({tag, " busy_cycles_a"}, 32'(cnt_a), 32'd16);
    check_eq({tag, " busy_cycles_b"}, 32'(cnt_b), 32'd16);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < NE; i++) do_read(AW'(i), 32'd0, 32'd0, tag);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; read_en = 1'b0; wr_en = 1'b0;
    read_addr = '0; write_addr = '0; write_data = '0; write_bytesel = '0;

    reset_and_wait("por");
    read_all_zero("por_zero");

    // byte enables
    do_write(4'd3, 32'hAABBCCDD, 4'b1111);
    do_write(4'd3, 32'h11223344, 4'b0101);
    do_read(4'd3, 32'hAA22CC44, 32'hAA22CC44, "bytesel");
    do_write(4'd3, 32'hFFFFFFFF, 4'b0000);
    do_read(4'd3, 32'hAA22CC44, 32'hAA22CC44, "be_zero");

    // same-address collisions
    do_write(4'd5, 32'h12345678, 4'b1111);
    wr_en = 1'b1; write_addr = 4'd5; write_data = 32'hCAFEF00D; write_bytesel = 4'b1111;
    do_read(4'd5, 32'hCAFEF00D, 32'h12345678, "same_full");
    do_read(4'd5, 32'hCAFEF00D, 32'hCAFEF00D, "after_same");
    wr_en = 1'b1; write_addr = 4'd5; write_data = 32'h0000BEEF; write_bytesel = 4'b0011;
    do_read(4'd5, 32'hCAFEBEEF, 32'hCAFEF00D, "same_part");

    // different addresses in the same cycle
    wr_en = 1'b1; write_addr = 4'd6; write_data = 32'hDEADBEEF; write_bytesel = 4'b1111;
    do_read(4'd5, 32'hCAFEBEEF, 32'hCAFEBEEF, "diff_addr");
    do_read(4'd6, 32'hDEADBEEF, 32'hDEADBEEF, "diff_addr_wr");

    // back-to-back reads of addresses 0..7
    for (int i = 0; i < 8; i++) do_write(AW'(i), 32'h100 + 32'(i), 4'b1111);
    for (int k = 0; k <= 10; k++) begin
      read_en = (k < 8); read_addr = AW'(k);
      tick();
      check_eq("b2b a_valid", 32'(valid_a), (k <= 7) ? 32'd1 : 32'd0);
      check_eq("b2b a_data", data_a, 32'h100 + 32'((k < 7) ? k : 7));
      check_eq("b2b b_valid", 32'(valid_b), (k >= 1 && k <= 8) ? 32'd1 : 32'd0);
      if (k >= 1) check_eq("b2b b_data", data_b, 32'h100 + 32'((k - 1 < 7) ? k - 1 : 7));
    end
    read_en = 1'b0;

    // clear, restarted 5 cycles later; a read on the clear cycle keeps old data
    clear = 1'b1; read_en = 1'b1; read_addr = 4'd3;
    tick();
    busy_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 1) begin
        check_eq("clr a_valid_pre", 32'(valid_a), 32'd1);
        check_eq("clr a_data_pre", data_a, 32'h103);
        check_eq("clr b_valid_early", 32'(valid_b), 32'd0);
      end else if (n == 2) begin
        check_eq("clr a_valid_busy", 32'(valid_a), 32'd0);
        check_eq("clr b_valid_pre", 32'(valid_b), 32'd1);
        check_eq("clr b_data_pre", data_b, 32'h103);
      end else begin
        check_eq("clr a_valid_busy", 32'(valid_a), 32'd0);
        check_eq("clr b_valid_busy", 32'(valid_b), 32'd0);
      end
      if (!busy_a) break;
      busy_cnt++;
      clear = (n == 5); read_en = 1'b1; read_addr = 4'd9;
      wr_en = 1'b1; write_addr = 4'd7; write_data = '1; write_bytesel = '1;
      tick();
    end
    clear = 1'b0; read_en = 1'b0; wr_en = 1'b0;
    check_eq("clr busy_done", 32'(busy_a | busy_b), 32'd0);
    check_eq("clr busy_cycles", 32'(busy_cnt), 32'd21);
    read_all_zero("clr_zero");

    // reset in the middle of a sweep
    do_write(4'd4, 32'h55AA55AA, 4'b1111);
    do_read(4'd4, 32'h55AA55AA, 32'h55AA55AA, "pre_rst");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (5) tick();
    check_eq("mid busy", 32'(busy_a), 32'd1);
    reset_and_wait("rst_mid");
    read_all_zero("rst_zero");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
